ex_mem_stage_skid: RTL
======================

// Module: ex_mem_stage_skid
// PURPOSE
//  Parametrised EX->MEM pipeline stage register for the scalar+vector core.
//  Adds a valid/ready handshake, a 2-entry skid buffer (registered in_ready), flush, and a stall counter.
//  Sits between the execute datapath and the memory stage.
//  Back-pressure from MEM never creates a combinational path back into EX.
// PARAMETERS
//  SCALAR_W   8   scalar ALU result / srcA / srcB width
//  LANE_W     8   vector lane width
//  LANES      16  vector lanes; vector data width VEC_W = LANES*LANE_W
//  VADDR_W    12  vector memory address width
//  RIDX_W     5   register index width (rs1, rs2, rd)
//  CNT_W      16  stall counter width
// PORTS
//  clk            in   1        clock
//  reset          in   1        synchronous, active-high reset
//  flush          in   1        kill all held entries and the current input
//  in_valid       in   1        EX presents a valid instruction
//  in_ready       out  1        stage can accept (registered)
//  in_wre/in_vwre/in_wbsel/in_memwe  in  1 each  scalar RF write, vector RF write, WB mux select, mem write enable
//  in_rs1/in_rs2/in_rd  in  RIDX_W   register indices
//  in_alu/in_srca/in_srcb  in  SCALAR_W   ALU result and operands
//  in_vaddr       in   VADDR_W  vector memory address
//  in_vdata       in   VEC_W    vector data
//  out_valid      out  1        MEM side holds a valid instruction
//  out_ready      in   1        MEM consumes the head entry this cycle
//  out_*          out  (same)   head-entry fields, one per in_* field
//  occupancy      out  2        entries held, 0..2
//  stall_cnt      out  CNT_W    cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  Storage: main entry M (drives out_*) and skid entry S, each with a valid bit.
//  Transfers:
//   - Input transfer = in_valid & in_ready.
//   - Output transfer = out_valid & out_ready.
//  in_ready: in_ready = !S.valid, from a flop.
//  Latency: 1 cycle, in_valid at edge N gives out_valid after edge N when M was empty or draining.
//  Per-edge update (no flush):
//   - M empty or draining, S empty: an input loads M.
//   - M held (!out_ready), input arrives: the input loads S.
//   - M draining, S full: S moves to M. in_ready was 0, so no input is accepted.
//  Full: occupancy=2, in_ready=0 until M drains. No entry is ever dropped or duplicated.
//  Simultaneous in/out transfer with occupancy 1: M takes the new entry and occupancy stays 1.
//  Order: strict FIFO; S is always younger than M.
//  Control gating:
//   - out_wre, out_vwre and out_memwe are forced 0 whenever out_valid=0, so MEM never needs to qualify them.
//   - out_wbsel and data fields hold their last value when out_valid=0.
//  Flush (highest priority below reset):
//   - Next edge clears M.valid and S.valid; the same-cycle input is discarded.
//   - Result: occupancy=0 and in_ready=1 after the edge.
//   - Data fields are not cleared.
//  Stall counter:
//   - Increments on each edge where out_valid & !out_ready; saturates at all-ones.
//   - Cleared only by reset.
//  Reset:
//   - Valid bits, occupancy, stall_cnt and every data/index field go to 0; in_ready=1 after the edge.
//   - Reset overrides flush and any in-flight transfer, including reset mid-stall with occupancy=2.
//  Index widths are uniformly RIDX_W for rs1, rs2 and rd; no truncation anywhere.
// TESTING
//  Streaming: in_valid=1 and out_ready=1 for 10 cycles, alu=1..10 -> out_alu 1..10, one cycle late, in_ready stays 1.
//  Skid fill:
//   - out_ready=0, send A(alu=0x11) then B(0x22) -> occupancy=2, in_ready=0, stall_cnt counts.
//   - Raise out_ready -> A then B, in order.
//  Flush at occupancy=2 with in_valid=1:
//   - Next cycle out_valid=0, out_wre=0, out_memwe=0, occupancy=0, in_ready=1.
//   - The flushed input never appears.
//  Gating: send wre=1,memwe=1 then idle -> out_wre and out_memwe drop to 0 with out_valid, out_alu is held.
//  Reset: reset mid-stall with occupancy=2 -> all outputs 0 and in_ready=1 next cycle; stall_cnt=0.
//  Saturation: CNT_W=4, hold a stall for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/ex_mem_stage_skid.sv
// EX->MEM pipeline register with a two-entry skid buffer.
// Back-pressure is absorbed by the skid entry, so in_ready is always registered.
module ex_mem_stage_skid #(
    parameter int SCALAR_W = 8,
    parameter int LANE_W   = 8,
    parameter int LANES    = 16,
    parameter int VADDR_W  = 12,
    parameter int RIDX_W   = 5,
    parameter int CNT_W    = 16,
    localparam int VEC_W   = LANES * LANE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_wre,
    input  logic                in_vwre,
    input  logic                in_wbsel,
    input  logic                in_memwe,
    input  logic [RIDX_W-1:0]   in_rs1,
    input  logic [RIDX_W-1:0]   in_rs2,
    input  logic [RIDX_W-1:0]   in_rd,
    input  logic [SCALAR_W-1:0] in_alu,
    input  logic [SCALAR_W-1:0] in_srca,
    input  logic [SCALAR_W-1:0] in_srcb,
    input  logic [VADDR_W-1:0]  in_vaddr,
    input  logic [VEC_W-1:0]    in_vdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_wre,
    output logic                out_vwre,
    output logic                out_wbsel,
    output logic                out_memwe,
    output logic [RIDX_W-1:0]   out_rs1,
    output logic [RIDX_W-1:0]   out_rs2,
    output logic [RIDX_W-1:0]   out_rd,
    output logic [SCALAR_W-1:0] out_alu,
    output logic [SCALAR_W-1:0] out_srca,
    output logic [SCALAR_W-1:0] out_srcb,
    output logic [VADDR_W-1:0]  out_vaddr,
    output logic [VEC_W-1:0]    out_vdata,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam int PW = 4 + 3 * RIDX_W + 3 * SCALAR_W + VADDR_W + VEC_W;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] m_pl;
    logic [PW-1:0] s_pl;
    logic [PW-1:0] m_pl_next;
    logic [PW-1:0] s_pl_next;
    logic          m_valid;
    logic          s_valid;
    logic          m_valid_next;
    logic          s_valid_next;
    logic          ready_q;
    logic          in_xfer;
    logic          out_xfer;
    logic          m_wre;
    logic          m_vwre;
    logic          m_memwe;

    assign in_pl = {in_wre, in_vwre, in_wbsel, in_memwe,
                    in_rs1, in_rs2, in_rd,
                    in_alu, in_srca, in_srcb,
                    in_vaddr, in_vdata};

    assign {m_wre, m_vwre, out_wbsel, m_memwe,
            out_rs1, out_rs2, out_rd,
            out_alu, out_srca, out_srcb,
            out_vaddr, out_vdata} = m_pl;

    assign in_ready  = ready_q;
    assign out_valid = m_valid;
    assign in_xfer   = in_valid & ready_q;
    assign out_xfer  = m_valid & out_ready;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    // Write enables are qualified here so MEM can use them unqualified.
    assign out_wre   = m_valid & m_wre;
    assign out_vwre  = m_valid & m_vwre;
    assign out_memwe = m_valid & m_memwe;

    // Next-state of the main/skid pair; S only ever holds the younger entry.
    always_comb begin
        m_valid_next = m_valid;
        s_valid_next = s_valid;
        m_pl_next    = m_pl;
        s_pl_next    = s_pl;
        if (flush) begin
            m_valid_next = 1'b0;
            s_valid_next = 1'b0;
        end else if (!m_valid || out_xfer) begin
            if (s_valid) begin
                m_pl_next    = s_pl;
                m_valid_next = 1'b1;
                s_valid_next = 1'b0;
            end else if (in_xfer) begin
                m_pl_next    = in_pl;
                m_valid_next = 1'b1;
            end else begin
                m_valid_next = 1'b0;
            end
        end else if (in_xfer) begin
            s_pl_next    = in_pl;
            s_valid_next = 1'b1;
        end
    end

    // Entry storage; in_ready is registered from the next skid state.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_pl    <= '0;
            s_pl    <= '0;
            ready_q <= 1'b1;
        end else begin
            m_valid <= m_valid_next;
            s_valid <= s_valid_next;
            m_pl    <= m_pl_next;
            s_pl    <= s_pl_next;
            ready_q <= !s_valid_next;
        end
    end

    // Saturating count of cycles where MEM holds off a valid head entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
